// File: rtl/adc_capture_buffer_if.sv
// Capture-buffer signal bundle: ADC/phase inputs, arm request, read port and status.
interface adc_capture_buffer_if;
  logic [7:0] ADC_Data;
  logic [7:0] Addr_Ref;
  logic       Arm;
  logic [7:0] Rd_Addr;
  logic [7:0] Rd_Data;
  logic       Busy;
  logic       Done;
  logic       Timeout;
  logic [8:0] Phase_Out;

  modport master (
    output ADC_Data, Addr_Ref, Arm, Rd_Addr,
    input  Rd_Data, Busy, Done, Timeout, Phase_Out
  );

  modport slave (
    input  ADC_Data, Addr_Ref, Arm, Rd_Addr,
    output Rd_Data, Busy, Done, Timeout, Phase_Out
  );
endinterface

// File: rtl/adc_capture_buffer.sv
// Triggered ADC capture: samples at the DDS rate, stores NSAMPLE samples after a
// rising level crossing and reports the DDS phase at the trigger instant.
module adc_capture_buffer #(
  parameter int unsigned NSAMPLE    = 256,
  parameter int unsigned Freq       = 1000,
  parameter int unsigned CLK_HZ     = 100000000,
  parameter int unsigned TRIG_LEVEL = 128,
  parameter int unsigned TIMEOUT    = 512
) (
  input logic                 clk_ADC,
  input logic                 Rst,
  adc_capture_buffer_if.slave bus
);

  localparam int unsigned DIV = CLK_HZ / (Freq * NSAMPLE);
  localparam int unsigned DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned AW  = (NSAMPLE > 1) ? $clog2(NSAMPLE) : 1;
  localparam int unsigned TW  = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {IDLE, WAIT_TRIG, CAPTURE, DONE} state_t;

  state_t          state;
  state_t          state_nxt;

  logic [DW-1:0]   div_cnt;
  logic            tick;
  logic [7:0]      prev;
  logic            first;
  logic [TW-1:0]   tcnt;
  logic [AW-1:0]   wr_addr;
  logic [7:0]      trig_ref;
  logic [7:0]      mem [NSAMPLE];

  logic            busy_q;
  logic            done_q;
  logic            timeout_q;
  logic [8:0]      phase_q;
  logic [7:0]      rd_q;

  logic            crossing;
  logic            tmo_hit;
  logic            arm_ok;
  logic            trigger;
  logic            last_wr;
  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic [16:0]     phase_prod;

  assign tick       = (div_cnt == DW'(DIV - 1));
  assign crossing   = (prev < 8'(TRIG_LEVEL)) && (bus.ADC_Data >= 8'(TRIG_LEVEL));
  assign tmo_hit    = (tcnt == TW'(TIMEOUT - 1));
  // Arm is only honoured when no capture is in flight
  assign arm_ok     = bus.Arm && ((state == IDLE) || (state == DONE));
  // The first tick after arming only primes prev, so it can never trigger
  assign trigger    = (state == WAIT_TRIG) && tick && !first && (crossing || tmo_hit);
  assign last_wr    = (state == CAPTURE) && tick && (wr_addr == AW'(NSAMPLE - 1));
  assign phase_prod = 17'(trig_ref) * 17'd360;

  // State register
  always_ff @(posedge clk_ADC) begin
    if (Rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (arm_ok)  state_nxt = WAIT_TRIG;
      WAIT_TRIG: if (trigger) state_nxt = CAPTURE;
      CAPTURE:   if (last_wr) state_nxt = DONE;
      DONE:      if (arm_ok)  state_nxt = WAIT_TRIG;
      default:                state_nxt = IDLE;
    endcase
  end

  // Buffer write strobes: trigger sample lands at 0, capture ticks at wr_addr
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = wr_addr;
    case (state)
      WAIT_TRIG: begin
        if (trigger) begin
          mem_we    = 1'b1;
          mem_waddr = '0;
        end
      end
      CAPTURE:   mem_we = tick;
      default:   mem_we = 1'b0;
    endcase
  end

  // Sample divider, trigger bookkeeping and registered status outputs
  always_ff @(posedge clk_ADC) begin
    if (Rst) begin
      div_cnt   <= '0;
      prev      <= '0;
      first     <= 1'b1;
      tcnt      <= '0;
      wr_addr   <= '0;
      trig_ref  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      phase_q   <= '0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (tick) prev <= bus.ADC_Data;

      if (arm_ok) begin
        first     <= 1'b1;
        tcnt      <= '0;
        timeout_q <= 1'b0;
      end else if ((state == WAIT_TRIG) && tick) begin
        first <= 1'b0;
        tcnt  <= tcnt + 1'b1;
      end

      if (trigger) begin
        trig_ref  <= bus.Addr_Ref;
        wr_addr   <= AW'(1);
        timeout_q <= tmo_hit && !crossing;
      end else if ((state == CAPTURE) && tick) begin
        wr_addr <= wr_addr + 1'b1;
      end

      busy_q <= (state_nxt == WAIT_TRIG) || (state_nxt == CAPTURE);
      done_q <= (state_nxt == DONE);
      if (last_wr) phase_q <= 9'(phase_prod >> 8);
    end
  end

  // Sample buffer write port; contents survive reset and re-arm
  always_ff @(posedge clk_ADC) begin
    if (mem_we && !Rst) mem[mem_waddr] <= bus.ADC_Data;
  end

  // Registered read port, read-first against a same-cycle write
  always_ff @(posedge clk_ADC) begin
    if (Rst) rd_q <= '0;
    else     rd_q <= mem[AW'(bus.Rd_Addr)];
  end

  assign bus.Rd_Data   = rd_q;
  assign bus.Busy      = busy_q;
  assign bus.Done      = done_q;
  assign bus.Timeout   = timeout_q;
  assign bus.Phase_Out = phase_q;

endmodule

// File: tb/tb_adc_capture_buffer.sv
// Directed bench for adc_capture_buffer with a 4-cycle sample divider.
module tb_adc_capture_buffer;

  localparam int unsigned NS    = 256;
  localparam int unsigned FREQ  = 1000;
  localparam int unsigned CLKHZ = 1024000;
  localparam int unsigned DIVB  = 4;

  logic clk_ADC = 1'b0;
  logic Rst;
  int   total = 0;
  int   bad   = 0;
  int   ecount = 0;
  int   d;

  always #5 clk_ADC = ~clk_ADC;

  adc_capture_buffer_if bus ();

  adc_capture_buffer #(
    .NSAMPLE(NS), .Freq(FREQ), .CLK_HZ(CLKHZ), .TRIG_LEVEL(128), .TIMEOUT(512)
  ) dut (
    .clk_ADC(clk_ADC),
    .Rst    (Rst),
    .bus    (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clk1();
    @(posedge clk_ADC);
    #1;
    ecount++;
  endtask

  // Advance to just after the next sample-tick edge
  task automatic tick_wait();
    do clk1(); while ((ecount % DIVB) != 0);
  endtask

  task automatic read_chk(input string tag, input int k, input logic [7:0] exp);
    bus.Rd_Addr = 8'(k);
    clk1();
    chk(tag, 32'(bus.Rd_Data), 32'(exp));
  endtask

  // Arm, then drive a ramp (one code per tick); Addr_Ref equals ref_cross when the code is 128
  task automatic run_ramp(input int start, input int step, input int ref_cross,
                          input int hold_lo, input int hold_hi, input int stop_at,
                          output int done_i);
    int v;
    done_i = -1;
    tick_wait();
    bus.ADC_Data = 8'(start);
    bus.Addr_Ref = 8'(start - 128 + ref_cross);
    bus.Arm      = 1'b1;
    clk1();
    chk("arm_busy", 32'(bus.Busy), 1);
    chk("arm_done_clr", 32'(bus.Done), 0);
    chk("arm_tmo_clr", 32'(bus.Timeout), 0);
    bus.Arm = 1'b0;
    for (int i = 0; i < 400; i++) begin
      v = start + step * i;
      bus.ADC_Data = 8'(v);
      bus.Addr_Ref = 8'(v - 128 + ref_cross);
      bus.Arm      = (i >= hold_lo) && (i <= hold_hi);
      tick_wait();
      if (i == stop_at) break;
      if (bus.Done) begin
        done_i = i;
        break;
      end
    end
    bus.Arm = 1'b0;
  endtask

  initial begin
    Rst          = 1'b1;
    bus.ADC_Data = 8'd0;
    bus.Addr_Ref = 8'd0;
    bus.Arm      = 1'b0;
    bus.Rd_Addr  = 8'd0;
    repeat (3) clk1();
    chk("rst_busy", 32'(bus.Busy), 0);
    chk("rst_done", 32'(bus.Done), 0);
    chk("rst_tmo", 32'(bus.Timeout), 0);
    chk("rst_phase", 32'(bus.Phase_Out), 0);
    chk("rst_rdata", 32'(bus.Rd_Data), 0);
    Rst    = 1'b0;
    ecount = 0;

    // No Arm: status must stay quiet whatever the ADC does
    for (int i = 0; i < 2000; i++) begin
      bus.ADC_Data = 8'(i * 7);
      clk1();
      chk("idle_status", {bus.Busy, bus.Done, bus.Timeout, bus.Phase_Out}, 0);
    end

    // Ramp capture, trigger at code 128 with Addr_Ref 64
    run_ramp(120, 1, 64, -1, -1, -1, d);
    chk("ramp_done_tick", 32'(d), 263);
    chk("ramp_done", 32'(bus.Done), 1);
    chk("ramp_busy", 32'(bus.Busy), 0);
    chk("ramp_tmo", 32'(bus.Timeout), 0);
    chk("ramp_phase", 32'(bus.Phase_Out), 90);
    read_chk("ramp_rd5", 5, 8'd133);
    for (int k = 0; k < 256; k++) read_chk("ramp_mem", k, 8'(128 + k));

    // Constant level: forced trigger on the 512th tick, read-first on a live write
    bus.ADC_Data = 8'd200;
    bus.Addr_Ref = 8'd128;
    tick_wait();
    bus.Arm = 1'b1;
    clk1();
    chk("rearm_busy", 32'(bus.Busy), 1);
    chk("rearm_done", 32'(bus.Done), 0);
    bus.Arm = 1'b0;
    d = -1;
    for (int i = 0; i < 800; i++) begin
      tick_wait();
      if (i == 510) chk("tmo_before", 32'(bus.Timeout), 0);
      if (i == 511) begin
        chk("tmo_forced", 32'(bus.Timeout), 1);
        chk("tmo_busy", 32'(bus.Busy), 1);
      end
      if (i == 520) bus.Rd_Addr = 8'd10;
      if (i == 521) chk("rd_first_old", 32'(bus.Rd_Data), 138);
      if (i == 522) chk("rd_first_new", 32'(bus.Rd_Data), 200);
      if (bus.Done) begin
        d = i;
        break;
      end
    end
    chk("tmo_done_tick", 32'(d), 766);
    chk("tmo_flag_done", 32'(bus.Timeout), 1);
    chk("tmo_phase", 32'(bus.Phase_Out), 180);
    for (int k = 0; k < 256; k++) read_chk("tmo_mem", k, 8'd200);

    // Arm held high during capture must not disturb it
    run_ramp(120, 1, 255, 20, 40, -1, d);
    chk("hold_done_tick", 32'(d), 263);
    chk("hold_phase", 32'(bus.Phase_Out), 358);
    chk("hold_tmo", 32'(bus.Timeout), 0);
    for (int k = 0; k < 256; k++) read_chk("hold_mem", k, 8'(128 + k));

    // Reset while wr_addr is 100: abort, keep partial buffer
    run_ramp(110, 3, 0, -1, -1, 105, d);
    chk("pre_rst_busy", 32'(bus.Busy), 1);
    Rst = 1'b1;
    clk1();
    Rst    = 1'b0;
    ecount = 0;
    chk("abort_busy", 32'(bus.Busy), 0);
    chk("abort_done", 32'(bus.Done), 0);
    chk("abort_tmo", 32'(bus.Timeout), 0);
    chk("abort_phase", 32'(bus.Phase_Out), 0);
    chk("abort_rdata", 32'(bus.Rd_Data), 0);
    for (int i = 0; i < 3; i++) begin
      bus.ADC_Data = (i == 1) ? 8'd250 : 8'd10;
      tick_wait();
      chk("abort_idle", {bus.Busy, bus.Done}, 0);
    end
    for (int k = 0; k < 100; k++) read_chk("abort_mem", k, 8'(128 + 3 * k));
    read_chk("abort_mem100", 100, 8'd228);

    // Phase at Addr_Ref 0
    run_ramp(120, 1, 0, -1, -1, -1, d);
    chk("ph0_done_tick", 32'(d), 263);
    chk("ph0_phase", 32'(bus.Phase_Out), 0);
    chk("ph0_done", 32'(bus.Done), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
